// File: rtl/stopwatch_defs.sv
// Shared stopwatch definitions: FSM state encodings, BCD digit bundle and
// default debounce sizing, used by the control stage and the counter/driver.
package stopwatch_defs;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_LAP     = 2'd2,
        ST_STOPPED = 2'd3
    } state_t;

    // 10 ms at 100 MHz; DB_W must satisfy 2**DB_W > DEBOUNCE_CYCLES.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int DB_W_DEFAULT            = 20;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } bcd4_t;

    function automatic logic is_counting(input state_t st);
        return (st == ST_RUNNING) || (st == ST_LAP);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-FF synchroniser, hold-time debounce and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_W            = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, keeping the synchroniser chain two stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // Accept the new level; only the rising direction is an event.
                level <= sync2;
                press <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: debounces start/lap/clear, runs the
// IDLE/RUNNING/LAP/STOPPED machine and selects live or lap-frozen digits.
module stopwatch_ctrl
    import stopwatch_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int DB_W            = DB_W_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    input  logic [3:0] s3,
    output logic       run,
    output logic       clear,
    output logic       hold,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [1:0] state
);

    logic       start_ev;
    logic       lap_ev;
    logic       clear_ev;
    logic [2:0] unused_levels;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_start (
        .clk(clk), .reset(reset), .btn_raw(btn_start),
        .level(unused_levels[0]), .press(start_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_lap (
        .clk(clk), .reset(reset), .btn_raw(btn_lap),
        .level(unused_levels[1]), .press(lap_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_clear (
        .clk(clk), .reset(reset), .btn_raw(btn_clear),
        .level(unused_levels[2]), .press(clear_ev)
    );

    state_t cur_state;
    state_t next_state;
    logic   clear_accept;
    bcd4_t  live;
    bcd4_t  lap_reg;
    bcd4_t  disp;

    assign live  = '{d3: s3, d2: s2, d1: s1, d0: s0};
    assign state = cur_state;
    assign {d3, d2, d1, d0} = disp;

    // Events are checked in clear > start > lap order within each state, so
    // only the highest-priority event that is legal here is acted on.
    // NOTE: both outputs get defaults before the case so no path leaves them
    // unassigned, which would otherwise infer latches.
    always_comb begin
        next_state   = cur_state;
        clear_accept = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                if (clear_ev)      clear_accept = 1'b1;
                else if (start_ev) next_state   = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (start_ev)      next_state = ST_STOPPED;
                else if (lap_ev)   next_state = ST_LAP;
            end
            ST_LAP: begin
                if (start_ev)      next_state = ST_STOPPED;
                else if (lap_ev)   next_state = ST_RUNNING;
            end
            ST_STOPPED: begin
                if (clear_ev) begin
                    next_state   = ST_IDLE;
                    clear_accept = 1'b1;
                end else if (start_ev) begin
                    next_state = ST_RUNNING;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: the lap register is a handful of flops, not a RAM, so it is reset
    // with everything else and never shows stale digits after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_IDLE;
            run       <= 1'b0;
            clear     <= 1'b0;
            hold      <= 1'b0;
            lap_reg   <= '0;
            disp      <= '0;
        end else begin
            cur_state <= next_state;
            run       <= is_counting(next_state);
            hold      <= (next_state == ST_LAP);
            clear     <= clear_accept;
            if (next_state == ST_LAP && cur_state != ST_LAP) begin
                lap_reg <= live;
            end
            // On LAP entry the captured value is the live value this edge.
            if (next_state == ST_LAP && cur_state == ST_LAP) begin
                disp <= lap_reg;
            end else begin
                disp <= live;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with a 4-cycle debounce: expectations
// are queued with a due cycle when buttons are driven and checked when due.
module tb_stopwatch_ctrl;

    localparam int DC  = 4;
    localparam int LAT = 2 + DC + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start;
    logic       btn_lap;
    logic       btn_clear;
    logic [3:0] s0, s1, s2, s3;
    logic       run;
    logic       clear;
    logic       hold;
    logic [3:0] d0, d1, d2, d3;
    logic [1:0] state;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DC), .DB_W(3)) dut (
        .clk(clk), .reset(reset),
        .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3),
        .run(run), .clear(clear), .hold(hold),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .state(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int t_drive  = 0;

    typedef struct {
        int          due;
        string       tag;
        logic        run;
        logic        clr;
        logic        hold;
        logic [1:0]  st;
        logic [15:0] d;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic expect_out(input int lat, input string tag, input logic run_e,
                              input logic clr_e, input logic hold_e,
                              input logic [1:0] st_e, input logic [15:0] d_e);
        exp_t e;
        e.due  = cyc + lat;
        e.tag  = tag;
        e.run  = run_e;
        e.clr  = clr_e;
        e.hold = hold_e;
        e.st   = st_e;
        e.d    = d_e;
        sb.push_back(e);
    endtask

    // Outputs change on posedge; compare due entries on the falling edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                exp_t e;
                e = sb[i];
                check({e.tag, ".due"},   32'(cyc),          32'(e.due));
                check({e.tag, ".run"},   32'(run),          32'(e.run));
                check({e.tag, ".clear"}, 32'(clear),        32'(e.clr));
                check({e.tag, ".hold"},  32'(hold),         32'(e.hold));
                check({e.tag, ".state"}, 32'(state),        32'(e.st));
                check({e.tag, ".d"},     {16'h0, d3, d2, d1, d0}, {16'h0, e.d});
                sb.delete(i);
            end
        end
    end

    task automatic set_s(input logic [15:0] v);
        {s3, s2, s1, s0} = v;
    endtask

    task automatic drive(input logic st, input logic lp, input logic cl);
        @(negedge clk);
        btn_start = st;
        btn_lap   = lp;
        btn_clear = cl;
        t_drive   = cyc;
    endtask

    // Hold the press past acceptance, release, and let the release debounce.
    task automatic settle();
        while (cyc < t_drive + 8) @(negedge clk);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        btn_clear = 1'b0;
        repeat (9) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        btn_clear = 1'b0;
        set_s(16'h0000);
        repeat (3) @(negedge clk);
        check("rst.run",   32'(run),   32'd0);
        check("rst.clear", 32'(clear), 32'd0);
        check("rst.hold",  32'(hold),  32'd0);
        check("rst.state", 32'(state), 32'd0);
        check("rst.d",     {16'h0, d3, d2, d1, d0}, 32'h0);
        reset = 1'b0;

        // Bounce rejection, then a clean hold starts the watch.
        drive(1, 0, 0);
        @(negedge clk) btn_start = 1'b0;
        @(negedge clk) btn_start = 1'b1;
        @(negedge clk) btn_start = 1'b0;
        @(negedge clk) btn_start = 1'b1;
        t_drive = cyc;
        for (int k = 1; k < LAT; k++) expect_out(k, "bounce", 0, 0, 0, 2'd0, 16'h0000);
        expect_out(LAT, "bounce_run", 1, 0, 0, 2'd1, 16'h0000);
        settle();

        // Start/stop.
        drive(1, 0, 0);
        expect_out(LAT - 1, "stop_pre", 1, 0, 0, 2'd1, 16'h0000);
        expect_out(LAT,     "stop",     0, 0, 0, 2'd3, 16'h0000);
        expect_out(LAT + 1, "stop_post", 0, 0, 0, 2'd3, 16'h0000);
        settle();

        // Lap freeze and release.
        set_s(16'h1234);
        drive(1, 0, 0);
        expect_out(LAT, "restart", 1, 0, 0, 2'd1, 16'h1234);
        settle();
        drive(0, 1, 0);
        expect_out(LAT - 1, "lap_pre", 1, 0, 0, 2'd1, 16'h1234);
        expect_out(LAT,     "lap_in",  1, 0, 1, 2'd2, 16'h1234);
        repeat (LAT) @(negedge clk);
        set_s(16'h1259);
        expect_out(1, "lap_frz1", 1, 0, 1, 2'd2, 16'h1234);
        expect_out(3, "lap_frz3", 1, 0, 1, 2'd2, 16'h1234);
        expect_out(12, "lap_frz12", 1, 0, 1, 2'd2, 16'h1234);
        settle();
        drive(0, 1, 0);
        expect_out(LAT - 1, "lap_out_pre", 1, 0, 1, 2'd2, 16'h1234);
        expect_out(LAT,     "lap_out",     1, 0, 0, 2'd1, 16'h1259);
        expect_out(LAT + 1, "lap_out_post", 1, 0, 0, 2'd1, 16'h1259);
        settle();

        // Clear ignored while running, accepted when stopped.
        drive(0, 0, 1);
        expect_out(LAT,     "clr_run",  1, 0, 0, 2'd1, 16'h1259);
        expect_out(LAT + 1, "clr_run2", 1, 0, 0, 2'd1, 16'h1259);
        settle();
        drive(1, 0, 0);
        expect_out(LAT, "stop2", 0, 0, 0, 2'd3, 16'h1259);
        settle();
        drive(0, 0, 1);
        expect_out(LAT - 1, "clr_pre",  0, 0, 0, 2'd3, 16'h1259);
        expect_out(LAT,     "clr",      0, 1, 0, 2'd0, 16'h1259);
        expect_out(LAT + 1, "clr_post", 0, 0, 0, 2'd0, 16'h1259);
        settle();

        // Simultaneous start + clear in STOPPED: clear wins.
        drive(1, 0, 0);
        expect_out(LAT, "run3", 1, 0, 0, 2'd1, 16'h1259);
        settle();
        drive(1, 0, 0);
        expect_out(LAT, "stop3", 0, 0, 0, 2'd3, 16'h1259);
        settle();
        drive(1, 0, 1);
        expect_out(LAT,     "sim",      0, 1, 0, 2'd0, 16'h1259);
        expect_out(LAT + 1, "sim_post", 0, 0, 0, 2'd0, 16'h1259);
        expect_out(LAT + 9, "sim_idle", 0, 0, 0, 2'd0, 16'h1259);
        settle();

        // Async reset in the middle of LAP.
        drive(1, 0, 0);
        expect_out(LAT, "run4", 1, 0, 0, 2'd1, 16'h1259);
        settle();
        drive(0, 1, 0);
        expect_out(LAT, "lap4", 1, 0, 1, 2'd2, 16'h1259);
        settle();
        set_s(16'h4321);
        expect_out(2, "lap4_frz", 1, 0, 1, 2'd2, 16'h1259);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst.run",   32'(run),   32'd0);
        check("arst.hold",  32'(hold),  32'd0);
        check("arst.clear", 32'(clear), 32'd0);
        check("arst.state", 32'(state), 32'd0);
        check("arst.d",     {16'h0, d3, d2, d1, d0}, 32'h0);
        @(negedge clk) reset = 1'b0;
        expect_out(2, "post_rst", 0, 0, 0, 2'd0, 16'h4321);
        repeat (4) @(negedge clk);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Front-end control stage for the stopwatch. It sits between the raw board buttons and the BCD counter, and between the counter and the display digit mux. It debounces three push-buttons and runs the start/stop/lap/clear state machine. It drives the counter's run level and clear pulse, and supplies the display with either live or lap-frozen BCD digits.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised button must hold a new level before it is accepted (10 ms at 100 MHz).
DB_W, 20, width of each debounce counter; must satisfy 2^DB_W > DEBOUNCE_CYCLES.

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high reset
btn_start  in  1  raw start/stop button, active-high, asynchronous to clk
btn_lap  in  1  raw lap button, active-high, asynchronous
btn_clear  in  1  raw clear button, active-high, asynchronous
s0,s1,s2,s3  in  4 each  live BCD digits from counter (s0 = LSD)
run  out  1  level to counter start/stop input; 1 = counting
clear  out  1  one-cycle synchronous clear pulse to counter
hold  out  1  1 while the display is frozen at a lap value
d0,d1,d2,d3  out  4 each  digits to display mux (d0 = LSD)
state  out  2  current FSM state (IDLE=0, RUNNING=1, LAP=2, STOPPED=3)

Behaviour:
- Reset is asynchronous and active-high. While asserted: run=0, clear=0, hold=0, state=IDLE, d0..d3=0, all synchronisers, debounced levels and debounce counters = 0.
- Per button: 2-FF synchroniser, then debounce.
  - Counter clears whenever the sync level equals the stable level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1, stable flips and the counter clears.
  - Any glitch back to the stable level before that point restarts the count.
  - Press event = one-cycle pulse on the rising edge of stable. Release generates no event.
- Latency: a clean press yields its event 2 + DEBOUNCE_CYCLES cycles after the raw input rises. The FSM registers outputs on the following edge.
- Event priority when events coincide in one cycle: clear > start > lap. Only the highest-priority legal event is acted on; the others are dropped, not queued.
- FSM transitions (events not listed are ignored):
  - IDLE: start -> RUNNING.
  - RUNNING: start -> STOPPED. lap -> LAP.
  - LAP: lap -> RUNNING. start -> STOPPED.
  - STOPPED: start -> RUNNING. clear -> IDLE.
  - clear in IDLE -> stay IDLE, still emits the clear pulse. clear in RUNNING or LAP is ignored.
- Outputs are registered, derived from the next state:
  - run = 1 in RUNNING and LAP.
  - hold = 1 only in LAP.
  - clear = 1 for exactly the cycle after an accepted clear event.
- Lap latch: on the edge that enters LAP, capture s0..s3 into the lap register.
  - In LAP, d0..d3 = lap register.
  - Otherwise d0..d3 = s0..s3, registered with 1-cycle delay.
  - Leaving LAP returns the display to live digits on the next cycle. The lap register keeps its value until the next LAP entry.
- STOPPED shows live, now frozen, counter digits. Entering STOPPED from LAP drops hold in the same cycle run falls.
- Reset mid-debounce or mid-LAP: everything returns to reset values immediately. A button still held when reset deasserts is seen as a new press once debounced.
- No arithmetic wrap concerns beyond the debounce counter. That counter saturates logically because it clears on acceptance.

Decomposition:
- Shared header stopwatch_defs: state encodings (ST_IDLE, ST_RUNNING, ST_LAP, ST_STOPPED) and the default DEBOUNCE_CYCLES, shared with the counter/driver.
- One sub-module, btn_debounce (params DEBOUNCE_CYCLES, DB_W; ports clk, reset, btn_raw, level, press), instantiated three times.
- The FSM and lap latch live in stopwatch_ctrl.

Test Plan (DEBOUNCE_CYCLES=4 in bench):
1. Bounce rejection: btn_start toggles 1,0,1,0 on successive cycles, then holds 1.
   - No event during bouncing.
   - run rises exactly 2+4+1 cycles after the final stable rise.
2. Start/stop: press start from IDLE -> run=1, state=1. Press again -> run=0, state=3. clear stays 0 throughout.
3. Lap: in RUNNING with s3..s0=1,2,3,4, press lap.
   - hold=1 and d3..d0 hold 1,2,3,4 while s changes to 1,2,5,9.
   - Second lap press -> hold=0 and d follows s the next cycle.
4. Clear:
   - In STOPPED, press clear -> clear high exactly one cycle, then state=0.
   - In RUNNING, press clear -> clear stays 0 and state stays 1.
5. Simultaneous: start and clear debounced in the same cycle while in STOPPED -> only clear acts; state=0, run=0.
6. Async reset: assert reset mid-LAP between clock edges -> run, hold and d0..d3 go to 0 without waiting for a clk edge. After release, state=0.
